// File: rtl/pulse_tx.sv
// Serial pulse-burst transmitter with a registered mirror of the downstream
// mod-3 pulse-counting detector.
module pulse_tx #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned GAP_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic [GAP_W-1:0] gap,
    output logic             pulse,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pulses_sent,
    output logic [1:0]       det_state,
    output logic             det_out
);

    typedef enum logic [1:0] {StIdle, StPulse, StGap, StDone} state_e;

    state_e             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_count, w_count_nxt;
    logic [GAP_W-1:0]   r_gap, w_gap_nxt;
    logic [GAP_W-1:0]   r_gap_cnt, w_gap_cnt_nxt;
    logic [CNT_W-1:0]   r_sent, w_sent_nxt;
    logic [1:0]         r_det, w_det_nxt;
    logic [CNT_W-1:0]   w_sent_inc;

    assign w_sent_inc = r_sent + CNT_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= StIdle;
            r_count   <= '0;
            r_gap     <= '0;
            r_gap_cnt <= '0;
            r_sent    <= '0;
            r_det     <= 2'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_gap     <= w_gap_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
            r_sent    <= w_sent_nxt;
            r_det     <= w_det_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_count_nxt   = r_count;
        w_gap_nxt     = r_gap;
        w_gap_cnt_nxt = r_gap_cnt;
        w_sent_nxt    = r_sent;
        w_det_nxt     = r_det;
        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_sent_nxt = '0;
                    if (count == '0) begin
                        w_state_nxt = StDone;
                    end else begin
                        w_count_nxt = count;
                        w_gap_nxt   = gap;
                        w_state_nxt = StPulse;
                    end
                end
            end
            StPulse: begin
                w_sent_nxt = w_sent_inc;
                // Detector wraps S3 back to S1, never to S0
                w_det_nxt  = (r_det == 2'd3) ? 2'd1 : r_det + 2'd1;
                if (w_sent_inc == r_count) begin
                    w_state_nxt = StDone;
                end else if (r_gap == '0) begin
                    w_state_nxt = StPulse;
                end else begin
                    w_gap_cnt_nxt = r_gap - GAP_W'(1);
                    w_state_nxt   = StGap;
                end
            end
            StGap: begin
                if (r_gap_cnt == '0) begin
                    w_state_nxt = StPulse;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt - GAP_W'(1);
                end
            end
            StDone: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    assign pulse       = (r_state == StPulse);
    assign busy        = (r_state == StPulse) || (r_state == StGap);
    assign done        = (r_state == StDone);
    assign pulses_sent = r_sent;
    assign det_state   = r_det;
    assign det_out     = (r_det == 2'd0) || (r_det == 2'd3);

endmodule

// File: tb/tb_pulse_tx.sv
// Directed self-checking bench for pulse_tx.
module tb_pulse_tx;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] count;
    logic [3:0] gap;
    logic       pulse;
    logic       busy;
    logic       done;
    logic [7:0] pulses_sent;
    logic [1:0] det_state;
    logic       det_out;

    int n_tests = 0;
    int n_fail  = 0;

    pulse_tx #(.CNT_W(8), .GAP_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .count       (count),
        .gap         (gap),
        .pulse       (pulse),
        .busy        (busy),
        .done        (done),
        .pulses_sent (pulses_sent),
        .det_state   (det_state),
        .det_out     (det_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Issue a start, then step until done while counting pulse and busy cycles.
    // Optionally keep start high with a different count during the burst.
    task automatic run_burst(input logic [7:0] c, input logic [3:0] g, input bit poke,
                             output int np, output int nb);
        int cyc;
        np    = 0;
        nb    = 0;
        cyc   = 0;
        start = 1'b1;
        count = c;
        gap   = g;
        tick();
        if (poke) begin
            count = 8'd7;
            gap   = 4'd0;
        end else begin
            start = 1'b0;
        end
        while (!done && cyc < 2000) begin
            np += int'(pulse);
            nb += int'(busy);
            cyc++;
            tick();
        end
        start = 1'b0;
        if (cyc >= 2000) check("burst_timeout", 32'd0, 32'd1);
        tick();
    endtask

    initial begin
        logic [3:0] exp_p, exp_d, exp_o;
        int np, nb;
        count = 8'd0;
        gap   = 4'd0;
        do_reset();

        check("rst_pulse", pulse, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_sent", pulses_sent, 8'd0);
        check("rst_det", det_state, 2'd0);
        check("rst_detout", det_out, 1'b1);

        // count=3 gap=0: per-cycle view of t+1..t+4
        exp_p = 4'b0111;
        exp_d = 4'b1000;
        exp_o = 4'b1001;
        start = 1'b1; count = 8'd3; gap = 4'd0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("b3_pulse%0d", i), pulse, exp_p[i]);
            check($sformatf("b3_done%0d", i), done, exp_d[i]);
            check($sformatf("b3_detout%0d", i), det_out, exp_o[i]);
            tick();
        end
        check("b3_sent_hold", pulses_sent, 8'd3);
        check("b3_idle_busy", busy, 1'b0);
        check("b3_idle_done", done, 1'b0);
        check("b3_det", det_state, 2'd3);

        // count=2 gap=2: pulse 1,0,0,1 with busy high throughout, then done
        exp_p = 4'b1001;
        start = 1'b1; count = 8'd2; gap = 4'd2;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("b2_pulse%0d", i), pulse, exp_p[3-i]);
            check($sformatf("b2_busy%0d", i), busy, 1'b1);
            tick();
        end
        check("b2_done", done, 1'b1);
        check("b2_busy_off", busy, 1'b0);
        check("b2_det", det_state, 2'd2);
        check("b2_detout", det_out, 1'b0);
        tick();

        // count=0: immediate done, no pulse, detector untouched
        start = 1'b1; count = 8'd0; gap = 4'd5;
        tick();
        start = 1'b0;
        check("b0_done", done, 1'b1);
        check("b0_pulse", pulse, 1'b0);
        check("b0_busy", busy, 1'b0);
        check("b0_sent", pulses_sent, 8'd0);
        check("b0_det", det_state, 2'd2);
        tick();
        check("b0_done_off", done, 1'b0);

        // start held during busy must be ignored
        do_reset();
        run_burst(8'd3, 4'd1, 1'b1, np, nb);
        check("ign_np", np, 32'd3);
        check("ign_nb", nb, 32'd5);
        check("ign_det", det_state, 2'd3);
        check("ign_busy", busy, 1'b0);
        run_burst(8'd1, 4'd0, 1'b0, np, nb);
        check("ign2_np", np, 32'd1);
        check("ign2_det", det_state, 2'd1);
        check("ign2_detout", det_out, 1'b0);

        // reset asserted in the gap of a count=5 gap=3 burst
        do_reset();
        start = 1'b1; count = 8'd5; gap = 4'd3;
        tick();
        start = 1'b0;
        check("mid_pulse1", pulse, 1'b1);
        tick();
        check("mid_in_gap", busy && !pulse, 1'b1);
        reset = 1'b1;
        #1;
        check("mid_rst_pulse", pulse, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_detout", det_out, 1'b1);
        check("mid_rst_sent", pulses_sent, 8'd0);
        tick();
        reset = 1'b0;
        run_burst(8'd1, 4'd0, 1'b0, np, nb);
        check("mid_np", np, 32'd1);
        check("mid_det", det_state, 2'd1);
        check("mid_sent", pulses_sent, 8'd1);

        // count=255 gap=0: longest burst, all back-to-back
        do_reset();
        run_burst(8'd255, 4'd0, 1'b0, np, nb);
        check("max_np", np, 32'd255);
        check("max_nb", nb, 32'd255);
        check("max_sent", pulses_sent, 8'd255);
        check("max_det", det_state, 2'd3);
        check("max_detout", det_out, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pulse_tx.md
PULSE_TX -- requirements
Module: pulse_tx

Interface
REQ-001 Parameter: CNT_W, default 8, width of the burst pulse count.
REQ-002 Parameter: GAP_W, default 4, width of the inter-pulse gap length.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: start  input  1  burst request; sampled only in IDLE.
REQ-006 Port: count  input  CNT_W  number of pulses in the burst; captured with an accepted start.
REQ-007 Port: gap  input  GAP_W  low cycles between consecutive pulses; captured with an accepted start.
REQ-008 Port: pulse  output  1  serial pulse line driving the downstream pulse-counting detector's input.
REQ-009 Port: busy  output  1  high while a burst is in progress (PULSE or GAP state).
REQ-010 Port: done  output  1  single-cycle burst-complete strobe.
REQ-011 Port: pulses_sent  output  CNT_W  pulses emitted in the current or most recent burst.
REQ-012 Port: det_state  output  2  mirror of the downstream detector state; encoding S0=0, S1=1, S2=2, S3=3.
REQ-013 Port: det_out  output  1  predicted detector output: 1 in S0 and S3, 0 in S1 and S2.

Function
REQ-014 The FSM SHALL have four states, IDLE, PULSE, GAP and DONE, with all outputs decoded from registered state or registered counters (no combinational path from inputs to outputs).
REQ-015 In IDLE, start=1 with count!=0 SHALL latch count and gap, clear pulses_sent to 0, and enter PULSE on the same edge, so pulse is high in the first cycle after start is sampled.
REQ-016 In IDLE, start=1 with count=0 SHALL clear pulses_sent and enter DONE with no pulse emitted.
REQ-017 PULSE SHALL last exactly one cycle with pulse=1, and pulses_sent SHALL increment by 1 at the end of that cycle.
REQ-018 On leaving PULSE: if this was the last pulse, go to DONE; else if latched gap=0, go to PULSE (back-to-back pulses); otherwise go to GAP.
REQ-019 GAP SHALL hold pulse=0 for exactly the latched gap cycles and then enter PULSE.
REQ-020 DONE SHALL assert done=1 for exactly one cycle and then return to IDLE; start SHALL be ignored in DONE.
REQ-021 start SHALL be ignored in PULSE and GAP; count and gap changes during a burst SHALL have no effect.
REQ-022 busy SHALL be 1 exactly in PULSE and GAP, and 0 in IDLE and DONE.
REQ-023 det_state SHALL update on each rising edge where pulse=1, using S0->S1, S1->S2, S2->S3, S3->S1, and SHALL hold when pulse=0.
REQ-024 det_state SHALL persist across bursts and SHALL be cleared only by reset.
REQ-025 Consequently, det_out SHALL be 1 exactly when the total pulses emitted since reset, mod 3, equal 0.
REQ-026 pulses_sent SHALL hold its final value after DONE until the next accepted start.
REQ-027 For a burst with count=N (N>=1) and gap=G, the burst SHALL occupy N + (N-1)*G cycles of busy, followed by one done cycle.

Reset
REQ-028 Asserting reset SHALL immediately force state=IDLE, pulse=0, busy=0, done=0, pulses_sent=0, det_state=S0 and det_out=1, including when asserted mid-burst.
REQ-029 After reset deasserts, the first accepted start SHALL behave identically to one accepted after power-up.

Verification
REQ-030 Reset; start at edge t with count=3, gap=0 -> pulse=1 in cycles t+1..t+3; done=1 in t+4; det_out goes 1,0,0,1; pulses_sent=3.
REQ-031 count=2, gap=2 -> pulse pattern 1,0,0,1; busy high for 4 cycles; done in the following cycle; det_state ends at S2 with det_out=0.
REQ-032 count=0 -> done=1 one cycle after start, pulse never high, det_state unchanged.
REQ-033 Burst count=3, then start pulsed during the first burst's busy (ignored), then burst count=1 -> only 4 pulses total; det_state goes S3->S1 with det_out=0.
REQ-034 Reset asserted during GAP of a count=5, gap=3 burst -> pulse, busy and done are 0 immediately; det_out=1; a new start with count=1 gives one pulse and det_state=S1.
REQ-035 count=255, gap=0 -> 255 consecutive pulse cycles, pulses_sent=255, det_state=S3, det_out=1.
